// File: rtl/cube_scan_driver.sv
// Refresh engine for an N x N x N LED cube: blank, load N latches, then light one layer.
// Define CUBE_DBUF_EN for a front/back frame store that swaps only on frame_done.
module cube_scan_driver #(
    parameter int unsigned N     = 8,
    parameter int unsigned DWELL = 4096,
    parameter int unsigned BLANK = 16,
    parameter int unsigned PULSE = 2
) (
    input  logic                 CLOCK_50,
    input  logic                 resetn,
    input  logic                 enable,
    input  logic                 wr_en,
    input  logic [$clog2(N)-1:0] wr_layer,
    input  logic [$clog2(N)-1:0] wr_latch,
    input  logic [N-1:0]         wr_data,
    output logic [N-1:0]         layers,
    output logic [N-1:0]         latches,
    output logic [N-1:0]         data,
    output logic [$clog2(N)-1:0] cur_layer,
    output logic                 frame_done
);
    localparam int unsigned LW     = $clog2(N);
    localparam int unsigned CntMax = (DWELL > BLANK) ? ((DWELL > PULSE) ? DWELL : PULSE)
                                                     : ((BLANK > PULSE) ? BLANK : PULSE);
    localparam int unsigned CW     = $clog2(CntMax + 1);

    typedef enum logic [2:0] {
        StIdle, StBlank, StFetch, StSetup, StStrobe, StHold, StShow
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [LW-1:0] layer_q, layer_d;
    logic [LW-1:0] lat_q, lat_d;
    logic          frame_done_q, frame_done_d;
    logic [N-1:0]  word_q;
    logic          rd_en;

`ifdef CUBE_DBUF_EN
    localparam int unsigned AW = 2 * LW + 1;
    logic          front_q, dirty_q;
    logic [AW-1:0] waddr, raddr;

    assign waddr = {~front_q, wr_layer, wr_latch};
    assign raddr = {front_q, layer_q, lat_q};

    // A swap without new content would show a stale bank, so it needs a write since the last one.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            front_q <= 1'b0;
            dirty_q <= 1'b0;
        end else if (frame_done_d && dirty_q) begin
            front_q <= ~front_q;
            dirty_q <= 1'b0;
        end else if (wr_en) begin
            dirty_q <= 1'b1;
        end
    end
`else
    localparam int unsigned AW = 2 * LW;
    logic [AW-1:0] waddr, raddr;

    assign waddr = {wr_layer, wr_latch};
    assign raddr = {layer_q, lat_q};
`endif

    logic [N-1:0] mem_q [1 << AW];

    always_ff @(posedge CLOCK_50) begin
        if (wr_en) begin
            mem_q[waddr] <= wr_data;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + 1'b1;
        layer_d      = layer_q;
        lat_d        = lat_q;
        frame_done_d = 1'b0;
        rd_en        = 1'b0;
        if (!enable) begin
            state_d = StIdle;
            cnt_d   = '0;
            layer_d = '0;
            lat_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StBlank;
                    cnt_d   = '0;
                    layer_d = '0;
                    lat_d   = '0;
                end
                StBlank: begin
                    if (cnt_q == CW'(BLANK - 1)) begin
                        state_d = StFetch;
                        lat_d   = '0;
                    end
                end
                StFetch: begin
                    rd_en   = 1'b1;
                    state_d = StSetup;
                end
                StSetup: begin
                    state_d = StStrobe;
                    cnt_d   = '0;
                end
                StStrobe: begin
                    if (cnt_q == CW'(PULSE - 1)) begin
                        state_d = StHold;
                    end
                end
                StHold: begin
                    cnt_d = '0;
                    if (lat_q == LW'(N - 1)) begin
                        state_d = StShow;
                    end else begin
                        lat_d   = lat_q + 1'b1;
                        state_d = StFetch;
                    end
                end
                StShow: begin
                    if (cnt_q == CW'(DWELL - 1)) begin
                        state_d = StBlank;
                        cnt_d   = '0;
                        if (layer_q == LW'(N - 1)) begin
                            layer_d      = '0;
                            frame_done_d = 1'b1;
                        end else begin
                            layer_d = layer_q + 1'b1;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            layer_q      <= '0;
            lat_q        <= '0;
            frame_done_q <= 1'b0;
            word_q       <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            layer_q      <= layer_d;
            lat_q        <= lat_d;
            frame_done_q <= frame_done_d;
            // Read port register doubles as the data bus hold; cleared so IDLE drives a dark bus.
            if (state_d == StIdle) begin
                word_q <= '0;
            end else if (rd_en) begin
                word_q <= mem_q[raddr];
            end
        end
    end

    // Outputs decode straight from state so an asynchronous reset darkens them at once.
    always_comb begin
        layers  = '0;
        latches = '0;
        if (state_q == StShow) begin
            layers[layer_q] = 1'b1;
        end
        if (state_q == StStrobe) begin
            latches[lat_q] = 1'b1;
        end
    end

    assign data       = word_q;
    assign cur_layer  = layer_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_cube_scan_driver.sv
// Bench for cube_scan_driver: random writes/enable drops checked against a model that derives
// every output from the elapsed scan time and a plain array copy of the frame store.
module tb_cube_scan_driver;
    localparam int unsigned N       = 4;
    localparam int unsigned DWELL   = 20;
    localparam int unsigned BLANK   = 3;
    localparam int unsigned PULSE   = 2;
    localparam int unsigned LW      = 2;
    localparam int unsigned LATCH_T = PULSE + 3;
    localparam int unsigned LOAD    = N * LATCH_T;
    localparam int unsigned P       = BLANK + LOAD + DWELL;
    localparam int unsigned FRAME   = N * P;
`ifdef CUBE_DBUF_EN
    localparam bit DBUF = 1'b1;
`else
    localparam bit DBUF = 1'b0;
`endif

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          enable   = 1'b0;
    logic          wr_en    = 1'b0;
    logic [LW-1:0] wr_layer = '0;
    logic [LW-1:0] wr_latch = '0;
    logic [N-1:0]  wr_data  = '0;
    logic [N-1:0]  layers, latches, data;
    logic [LW-1:0] cur_layer;
    logic          frame_done;

    cube_scan_driver #(
        .N     (N),
        .DWELL (DWELL),
        .BLANK (BLANK),
        .PULSE (PULSE)
    ) dut (
        .CLOCK_50   (clk),
        .resetn     (rst_n),
        .enable     (enable),
        .wr_en      (wr_en),
        .wr_layer   (wr_layer),
        .wr_latch   (wr_latch),
        .wr_data    (wr_data),
        .layers     (layers),
        .latches    (latches),
        .data       (data),
        .cur_layer  (cur_layer),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Model: scanning flag, cycles since BLANK entry, frame store per bank with valid bits.
    bit           running  = 1'b0;
    int unsigned  t        = 0;
    bit           front    = 1'b0;
    bit           dirty    = 1'b0;
    logic [N-1:0] mm [2][N][N];
    bit           mv [2][N][N];
    logic [N-1:0] exp_word = '0;
    bit           exp_ok   = 1'b0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (time %0t)", tag, act, exp, $time);
        end
    endtask

    // One clock: check this cycle's outputs, drive inputs for the next edge, advance the model.
    task automatic cycle(input bit en, input bit we, input int unsigned wl, input int unsigned wa,
                         input logic [N-1:0] wd);
        int unsigned  p, r, lat, lyr, wb;
        logic [N-1:0] e_layers, e_latches;
        bit           fetch, chk_data, fd_next, swap;
        @(negedge clk);
        p = t % P;
        lyr = running ? (t / P) % N : 0;
        lat = 0;
        r = 0;
        fetch = 1'b0;
        chk_data = 1'b0;
        e_layers = '0;
        e_latches = '0;
        if (running && p >= BLANK + LOAD) begin
            e_layers[lyr] = 1'b1;
            chk_data = 1'b1;
        end else if (running && p >= BLANK) begin
            lat = (p - BLANK) / LATCH_T;
            r = (p - BLANK) % LATCH_T;
            fetch = (r == 0);
            chk_data = (r != 0);
            if (r >= 2 && r < 2 + PULSE) e_latches[lat] = 1'b1;
        end
        check("layers", 32'(layers), 32'(e_layers));
        check("latches", 32'(latches), 32'(e_latches));
        check("cur_layer", 32'(cur_layer), 32'(lyr));
        check("frame_done", 32'(frame_done), 32'(running && t > 0 && t % FRAME == 0));
        check("latch_onehot", 32'($onehot0(latches)), 32'(1));
        check("dark_while_loading", 32'(|layers && |latches), 32'(0));
        if (!running) check("data_idle", 32'(data), 32'(0));
        else if (chk_data && exp_ok) check("data", 32'(data), 32'(exp_word));
        if (fetch) begin
            exp_word = mm[front][lyr][lat];
            exp_ok   = mv[front][lyr][lat];
        end

        enable   = en;
        wr_en    = we;
        wr_layer = LW'(wl);
        wr_latch = LW'(wa);
        wr_data  = wd;

        wb = (DBUF && !front) ? 1 : 0;
        if (we) begin
            mm[wb][wl][wa] = wd;
            mv[wb][wl][wa] = 1'b1;
        end
        fd_next = 1'b0;
        if (!running) begin
            if (en) begin
                running = 1'b1;
                t = 0;
            end
        end else if (!en) begin
            running = 1'b0;
        end else begin
            t++;
            fd_next = (t % FRAME == 0);
        end
        swap  = DBUF && fd_next && dirty;
        dirty = !swap && (dirty || we);
        if (swap) front = !front;
    endtask

    task automatic idle_scan(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) cycle(1'b1, 1'b0, 0, 0, '0);
    endtask

    // Scan until the model reaches position p of layer lyr; bounded.
    task automatic wait_at(input int unsigned lyr, input int unsigned p, input int unsigned bound);
        int unsigned n = 0;
        while (!(running && (t / P) % N == lyr && t % P == p) && n < bound) begin
            cycle(1'b1, 1'b0, 0, 0, '0);
            n++;
        end
        if (n >= bound) check("wait_timeout", 32'(n), 32'(0));
    endtask

    initial begin
        for (int unsigned b = 0; b < 2; b++)
            for (int unsigned l = 0; l < N; l++)
                for (int unsigned a = 0; a < N; a++) mv[b][l][a] = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_layers", 32'(layers), 32'(0));
        check("rst_latches", 32'(latches), 32'(0));
        check("rst_data", 32'(data), 32'(0));
        check("rst_cur_layer", 32'(cur_layer), 32'(0));
        check("rst_frame_done", 32'(frame_done), 32'(0));
        rst_n = 1'b1;

        // Content frame: only word(2,1) is nonzero; written idle, then again while scanning.
        for (int unsigned l = 0; l < N; l++)
            for (int unsigned a = 0; a < N; a++)
                cycle(1'b0, 1'b1, l, a, (l == 2 && a == 1) ? 4'hA : 4'h0);
        idle_scan(FRAME + 10);
        for (int unsigned l = 0; l < N; l++)
            for (int unsigned a = 0; a < N; a++)
                cycle(1'b1, 1'b1, l, a, (l == 2 && a == 1) ? 4'hA : 4'h0);
        idle_scan(2 * FRAME);

        // Collision: write word(0,0) on its own FETCH cycle.
        cycle(1'b1, 1'b1, 0, 0, 4'h3);
        wait_at(0, BLANK, 2 * FRAME);
        cycle(1'b1, 1'b1, 0, 0, 4'h5);
        idle_scan(2 * FRAME + 10);

        // Enable drop on the first strobe cycle of latch 1 in layer 2.
        wait_at(2, BLANK + LATCH_T + 2, 2 * FRAME);
        cycle(1'b0, 1'b0, 0, 0, '0);
        for (int unsigned i = 0; i < 4; i++) cycle(1'b0, 1'b0, 0, 0, '0);
        idle_scan(P + 5);

        // Full new frame written mid-frame, then a frame with no writes.
        wait_at(1, BLANK + LOAD + 3, 2 * FRAME);
        for (int unsigned l = 0; l < N; l++)
            for (int unsigned a = 0; a < N; a++)
                cycle(1'b1, 1'b1, l, a, N'($urandom));
        idle_scan(3 * FRAME);

        for (int unsigned i = 0; i < 2500; i++)
            cycle(($urandom % 400) != 0, ($urandom % 6) == 0, $urandom % N, $urandom % N,
                  N'($urandom));

        // Asynchronous reset in the middle of a SHOW dwell.
        wait_at(1, BLANK + LOAD + 5, 2 * FRAME);
        cycle(1'b1, 1'b0, 0, 0, '0);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_layers", 32'(layers), 32'(0));
        check("async_rst_latches", 32'(latches), 32'(0));
        check("async_rst_data", 32'(data), 32'(0));
        check("async_rst_cur_layer", 32'(cur_layer), 32'(0));
        check("async_rst_frame_done", 32'(frame_done), 32'(0));
        running = 1'b0;
        front   = 1'b0;
        dirty   = 1'b0;
        @(negedge clk);
        enable = 1'b0;
        wr_en  = 1'b0;
        rst_n  = 1'b1;
        cycle(1'b0, 1'b0, 0, 0, '0);
        idle_scan(FRAME + P);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cube_scan_driver.md
Name: cube_scan_driver

Overview:
Parametrised refresh engine for the N×N×N LED cube board. It holds an N·N-word frame buffer of N-bit row words and scans it continuously, one layer at a time. For each layer it blanks the layer drivers, loads the N latch ICs through the shared data bus, then lights the layer for a fixed dwell. It replaces manual switch-driven loading of layers, latches and data, and sits between the host write logic and the GPIO_0 pin mapping.

Parameters:
N, 8, cube edge: layer count, latch count and data-bus width
DWELL, 4096, clock cycles a layer stays lit per visit (≥1)
BLANK, 16, cycles with all layers off before loading a layer (≥1)
PULSE, 2, cycles a latch strobe is held high (≥1)

Ports:
CLOCK_50  in  1  system clock; all logic on rising edge
resetn  in  1  asynchronous, active-low reset
enable  in  1  1 = scan; 0 = outputs dark, engine idle
wr_en  in  1  frame-buffer write strobe
wr_layer  in  $clog2(N)  write address: layer
wr_latch  in  $clog2(N)  write address: latch within layer
wr_data  in  N  row word; bit k drives data line k
layers  out  N  one-hot layer drive, active-high
latches  out  N  latch strobes; latch captures on rising edge
data  out  N  shared latch data bus
cur_layer  out  $clog2(N)  layer currently loading or lit
frame_done  out  1  one-cycle pulse after layer N-1 dwell ends

Behaviour:
- Reset (async assert): state IDLE; layers, latches, data, cur_layer and frame_done = 0. Frame buffer contents are not cleared.
- FSM states are IDLE, BLANK, FETCH, SETUP, STROBE, HOLD and SHOW.
- IDLE: all outputs 0. Moves to BLANK with cur_layer = 0 on the first cycle enable = 1.
- BLANK: layers = 0 for BLANK cycles. Latch index i = 0. Then go to FETCH.
- FETCH: 1 cycle. Issues a buffer read of (cur_layer, i); read latency is 1.
- SETUP: 1 cycle. data = word(cur_layer, i); latches = 0.
- STROBE: PULSE cycles. latches[i] = 1 and data is held.
- HOLD: 1 cycle. latches = 0 and data is held.
  - If i < N-1: i++ and go to FETCH.
  - Else go to SHOW.
- Per-latch cost is PULSE+3 cycles. The layers output stays 0 from BLANK through HOLD.
- SHOW: layers = 1<<cur_layer for DWELL cycles; data holds the last word.
  - At the end of SHOW, if cur_layer = N-1: frame_done = 1 for one cycle and cur_layer wraps to 0.
  - Otherwise cur_layer++.
  - Either way, go to BLANK.
- Layer period is BLANK + N·(PULSE+3) + DWELL cycles; frame period is N times that.
- Writes are accepted every cycle with no backpressure and take effect the next cycle.
- Write and read to the same address in the same cycle: the read returns the old word.
- enable = 0 in any non-IDLE state: the next cycle enters IDLE, forcing all outputs to 0 and cur_layer = 0. A partial latch pulse is cut short. The next scan restarts from layer 0.
- Reset mid-operation behaves identically to enable = 0, plus frame_done is cleared.
- layers is never non-zero while any latch bit is 1.
- latches is never more than one-hot.

Optional Feature:
CUBE_DBUF_EN.
- Defined: two banks, front (scanned) and back (written). The swap happens on the cycle frame_done pulses, and only if at least one write landed since the last swap. A frame is therefore never displayed torn. After reset the front bank is bank 0 and writes target bank 1.
- Undefined: single bank; writes go straight to the scanned buffer and may show mid-frame.

Test Plan:
- Timing, N=4, DWELL=20, BLANK=3, PULSE=2, enable=1 after reset: the first latches[0] rise occurs 5 cycles after BLANK entry. layers = 4'b0001 for exactly 20 cycles. frame_done pulses every 4·(3+20+20) = 172 cycles.
- Content, N=4: write word(2,1) = 4'hA and all other words = 0. While latches[1] is high during the layer-2 load, data must read 4'hA. During every other strobe data must read 0.
- Collision: write word(0,0) = 4'h5 on the exact FETCH cycle of (0,0). That pass strobes the old value; the next frame strobes 4'h5.
- Enable drop: deassert during STROBE of layer 2. Next cycle all outputs are 0. On reassert, the first SHOW lights layer 0.
- Reset mid-SHOW: pull resetn low asynchronously between clock edges. layers goes to 0 immediately with no clock edge. Buffer contents survive and appear on the next scan.
- CUBE_DBUF_EN: write a full new frame mid-frame. Old data is displayed until frame_done, new data from the first strobe after it. A frame with no writes causes no swap.
